vga_layer_renderer: RTL and testbench



---
 rtl/vga_layer_renderer.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_layer_renderer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_layer_renderer.sv
// vga_layer_renderer
// VGA timing generator with a prioritised rectangle compositor. Game logic
// writes rectangles into a shadow set at any time; the shadow set is copied
// to the active set on the last pixel tick of each frame, so every frame is
// drawn from one consistent set of rectangles.
// Optional feature: define RECT_BLINK_EN to add the blink_mask input and a
// 6-bit frame counter. Masked layers are hidden while counter bit 5 is set,
// which gives 32 frames shown followed by 32 frames hidden.
module vga_layer_renderer #(
    parameter int         CLK_DIV  = 4,
    parameter int         H_DISP   = 640,
    parameter int         H_FP     = 16,
    parameter int         H_SYNC   = 96,
    parameter int         H_BP     = 48,
    parameter int         V_DISP   = 480,
    parameter int         V_FP     = 10,
    parameter int         V_SYNC   = 2,
    parameter int         V_BP     = 33,
    parameter int         NUM_RECT = 4,
    parameter int         CW       = 10,
    parameter logic [2:0] BG_RGB   = 3'b101,
    localparam int        IDX_W    = (NUM_RECT > 1) ? $clog2(NUM_RECT) : 1
) (
    input  logic                board_clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [CW-1:0]       wr_x1,
    input  logic [CW-1:0]       wr_x2,
    input  logic [CW-1:0]       wr_y1,
    input  logic [CW-1:0]       wr_y2,
    input  logic [2:0]          wr_rgb,
    input  logic                wr_vis,
`ifdef RECT_BLINK_EN
    input  logic [NUM_RECT-1:0] blink_mask,
`endif
    output logic                hsync,
    output logic                vsync,
    output logic [2:0]          rgb,
    output logic                video_on,
    output logic [CW-1:0]       pixel_x,
    output logic [CW-1:0]       pixel_y,
    output logic                p_tick,
    output logic                frame_start
);

    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]    H_VIS_END    = CW'(H_DISP);
    localparam logic [CW-1:0]    V_VIS_END    = CW'(V_DISP);
    localparam logic [CW-1:0]    H_SYNC_START = CW'(H_DISP + H_FP);
    localparam logic [CW-1:0]    H_SYNC_END   = CW'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0]    V_SYNC_START = CW'(V_DISP + V_FP);
    localparam logic [CW-1:0]    V_SYNC_END   = CW'(V_DISP + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic [CW-1:0] x1;
        logic [CW-1:0] x2;
        logic [CW-1:0] y1;
        logic [CW-1:0] y2;
        logic [2:0]    rgb;
        logic          vis;
    } rect_t;

    logic [DIV_W-1:0]    r_div;
    logic                r_pTick;
    logic [CW-1:0]       r_hCnt;
    logic [CW-1:0]       r_vCnt;
    rect_t               r_shadow [NUM_RECT];
    rect_t               r_active [NUM_RECT];
    logic                r_hsync;
    logic                r_vsync;
    logic [2:0]          r_rgb;
    logic                r_videoOn;
    logic [CW-1:0]       r_pixelX;
    logic [CW-1:0]       r_pixelY;
    logic                r_frameStart;

    logic [DIV_W-1:0]    w_divNext;
    logic                w_hAtLast;
    logic                w_vAtLast;
    logic                w_copy;
    logic                w_visible;
    logic [NUM_RECT-1:0] w_layerOn;
    logic [2:0]          w_hitRgb;

`ifdef RECT_BLINK_EN
    logic [5:0]          r_frameCnt;
`endif

    assign w_divNext = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    assign w_hAtLast = (r_hCnt == H_LAST);
    assign w_vAtLast = (r_vCnt == V_LAST);
    assign w_copy    = r_pTick && w_hAtLast && w_vAtLast;
    assign w_visible = (r_hCnt < H_VIS_END) && (r_vCnt < V_VIS_END);

    // Pixel-rate divider; the tick flag is registered so it lines up with the count reaching CLK_DIV-1.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_div   <= '0;
            r_pTick <= 1'b0;
        end else begin
            r_div   <= w_divNext;
            r_pTick <= (w_divNext == DIV_LAST);
        end
    end

    // Stage 0 raster counters, advancing once per pixel tick.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (r_pTick) begin
            if (w_hAtLast) begin
                r_hCnt <= '0;
                r_vCnt <= w_vAtLast ? '0 : r_vCnt + 1'b1;
            end else begin
                r_hCnt <= r_hCnt + 1'b1;
            end
        end
    end

    // Shadow rectangle writes from game logic; indices with no layer match no entry and are dropped.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_RECT; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_RECT; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    r_shadow[i] <= '{x1: wr_x1, x2: wr_x2, y1: wr_y1, y2: wr_y2,
                                     rgb: wr_rgb, vis: wr_vis};
                end
            end
        end
    end

    // Frame-boundary copy; a write landing in the same cycle only reaches the shadow set.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_RECT; i++) begin
                r_active[i] <= '0;
            end
        end else if (w_copy) begin
            for (int i = 0; i < NUM_RECT; i++) begin
                r_active[i] <= r_shadow[i];
            end
        end
    end

`ifdef RECT_BLINK_EN
    // Frame counter bumped at the boundary so frame n after reset is drawn with count n.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_frameCnt <= '0;
        end else if (w_copy) begin
            r_frameCnt <= r_frameCnt + 1'b1;
        end
    end
`endif

    // Per-layer enable, with blinking layers suppressed during the off half of the blink period.
    always_comb begin
        w_layerOn = '0;
        for (int i = 0; i < NUM_RECT; i++) begin
`ifdef RECT_BLINK_EN
            w_layerOn[i] = r_active[i].vis && !(blink_mask[i] && r_frameCnt[5]);
`else
            w_layerOn[i] = r_active[i].vis;
`endif
        end
    end

    // Priority composite: scan from the lowest priority up so layer 0 has the final say.
    always_comb begin
        w_hitRgb = BG_RGB;
        for (int i = NUM_RECT - 1; i >= 0; i--) begin
            if (w_layerOn[i] &&
                (r_active[i].x1 <= r_hCnt) && (r_hCnt <= r_active[i].x2) &&
                (r_active[i].y1 <= r_vCnt) && (r_vCnt <= r_active[i].y2)) begin
                w_hitRgb = r_active[i].rgb;
            end
        end
    end

    // Stage 1 output registers, all loaded on the same tick so every output describes one pixel.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_rgb        <= 3'b000;
            r_videoOn    <= 1'b0;
            r_pixelX     <= '0;
            r_pixelY     <= '0;
            r_frameStart <= 1'b0;
        end else if (r_pTick) begin
            r_hsync      <= !((r_hCnt >= H_SYNC_START) && (r_hCnt <= H_SYNC_END));
            r_vsync      <= !((r_vCnt >= V_SYNC_START) && (r_vCnt <= V_SYNC_END));
            r_rgb        <= w_visible ? w_hitRgb : 3'b000;
            r_videoOn    <= w_visible;
            r_pixelX     <= r_hCnt;
            r_pixelY     <= r_vCnt;
            r_frameStart <= (r_hCnt == '0) && (r_vCnt == '0);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;
    assign video_on    = r_videoOn;
    assign pixel_x     = r_pixelX;
    assign pixel_y     = r_pixelY;
    assign p_tick      = r_pTick;
    assign frame_start = r_frameStart;

endmodule

// File: tb/tb_vga_layer_renderer.sv
// Testbench for vga_layer_renderer using a shrunken raster (25x17 ticks,
// 3 board clocks per tick) so that many frames fit in a short run.
module tb_vga_layer_renderer;

    localparam int D   = 3;
    localparam int HD  = 16;
    localparam int HF  = 3;
    localparam int HS  = 4;
    localparam int HB  = 2;
    localparam int VD  = 10;
    localparam int VF  = 2;
    localparam int VS  = 3;
    localparam int VB  = 2;
    localparam int NR  = 3;
    localparam int CWB = 6;
    localparam int HT  = HD + HF + HS + HB;
    localparam int VT  = VD + VF + VS + VB;
    localparam int FR  = HT * VT;
    localparam logic [2:0] BG = 3'b101;

    logic           board_clk = 1'b0;
    logic           reset     = 1'b0;
    logic           wr_en     = 1'b0;
    logic [1:0]     wr_idx    = '0;
    logic [CWB-1:0] wr_x1     = '0;
    logic [CWB-1:0] wr_x2     = '0;
    logic [CWB-1:0] wr_y1     = '0;
    logic [CWB-1:0] wr_y2     = '0;
    logic [2:0]     wr_rgb    = '0;
    logic           wr_vis    = 1'b0;
    logic           hsync;
    logic           vsync;
    logic [2:0]     rgb;
    logic           video_on;
    logic [CWB-1:0] pixel_x;
    logic [CWB-1:0] pixel_y;
    logic           p_tick;
    logic           frame_start;

    int nCompared   = 0;
    int nMismatched = 0;

    vga_layer_renderer #(
        .CLK_DIV(D), .H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .NUM_RECT(NR), .CW(CWB), .BG_RGB(BG)
    ) dut (
        .board_clk(board_clk), .reset(reset),
        .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_y1(wr_y1), .wr_y2(wr_y2),
        .wr_rgb(wr_rgb), .wr_vis(wr_vis),
`ifdef RECT_BLINK_EN
        .blink_mask('0),
`endif
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .p_tick(p_tick), .frame_start(frame_start)
    );

    always #5 board_clk = ~board_clk;

    // Reference model: rectangles as plain records, raster position derived from the cycle count.
    typedef struct {
        int         x1;
        int         x2;
        int         y1;
        int         y2;
        logic [2:0] rgb;
        bit         vis;
    } rect_t;

    rect_t          mShd [NR];
    rect_t          mAct [NR];
    int             mCyc = 0;
    logic           mHs  = 1'b1;
    logic           mVs  = 1'b1;
    logic [2:0]     mRgb = 3'b000;
    logic           mVid = 1'b0;
    logic [CWB-1:0] mPx  = '0;
    logic [CWB-1:0] mPy  = '0;
    logic           mFs  = 1'b0;

    function automatic logic [2:0] modelRgb(input int h, input int v);
        if (!(h < HD && v < VD)) return 3'b000;
        for (int i = 0; i < NR; i++) begin
            if (mAct[i].vis && mAct[i].x1 <= h && h <= mAct[i].x2 &&
                mAct[i].y1 <= v && v <= mAct[i].y2) return mAct[i].rgb;
        end
        return BG;
    endfunction

    // Model update: pixel k (counted from reset release) is presented after board clock (k+1)*D.
    always @(posedge board_clk) begin
        int pIdx;
        int h;
        int v;
        if (reset) begin
            mCyc = 0;
            mHs = 1'b1; mVs = 1'b1; mRgb = 3'b000; mVid = 1'b0;
            mPx = '0; mPy = '0; mFs = 1'b0;
            for (int i = 0; i < NR; i++) begin
                mShd[i] = '{default: 0};
                mAct[i] = '{default: 0};
            end
        end else begin
            mCyc++;
            if (mCyc % D == 0) begin
                pIdx = mCyc / D - 1;
                h = pIdx % HT;
                v = (pIdx / HT) % VT;
                mPx  = CWB'(h);
                mPy  = CWB'(v);
                mVid = (h < HD) && (v < VD);
                mHs  = !(h >= HD + HF && h < HD + HF + HS);
                mVs  = !(v >= VD + VF && v < VD + VF + VS);
                mRgb = modelRgb(h, v);
                mFs  = (h == 0) && (v == 0);
                if (pIdx % FR == FR - 1) mAct = mShd;
            end
            if (wr_en && int'(wr_idx) < NR) begin
                mShd[int'(wr_idx)] = '{x1: int'(wr_x1), x2: int'(wr_x2),
                                      y1: int'(wr_y1), y2: int'(wr_y2),
                                      rgb: wr_rgb, vis: wr_vis};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s at t=%0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Every-cycle comparison of all outputs against the model, half a clock after the edge.
    always @(negedge board_clk) begin
        logic [19:0] act;
        logic [19:0] exp;
        act = {hsync, vsync, rgb, video_on, pixel_x, pixel_y, p_tick, frame_start};
        if (reset) exp = {1'b1, 1'b1, 3'b000, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0};
        else       exp = {mHs, mVs, mRgb, mVid, mPx, mPy, (mCyc % D == D - 1), mFs};
        checkOutput("cycle{hs,vs,rgb,vid,x,y,tick,fs}", 32'(act), 32'(exp));
    end

    task automatic applyStimulus(input int idx, input int x1, input int x2, input int y1,
                                 input int y2, input logic [2:0] c, input logic vis);
        @(posedge board_clk); #2;
        wr_en = 1'b1; wr_idx = 2'(idx);
        wr_x1 = CWB'(x1); wr_x2 = CWB'(x2); wr_y1 = CWB'(y1); wr_y2 = CWB'(y2);
        wr_rgb = c; wr_vis = vis;
        @(posedge board_clk); #2;
        wr_en = 1'b0;
    endtask

    task automatic waitFrameStart(input int limit);
        logic prev = 1'b1;
        bit   seen = 1'b0;
        int   n    = 0;
        while (!seen && n < limit) begin
            @(negedge board_clk);
            n++;
            if (frame_start && !prev) seen = 1'b1;
            prev = frame_start;
        end
        checkOutput("frameStartSeen", 32'(seen), 32'd1);
    endtask

    task automatic checkPixel(input int x, input int y, input logic [2:0] expRgb);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 2 * FR * D) begin
            @(negedge board_clk);
            n++;
            hit = (int'(pixel_x) == x) && (int'(pixel_y) == y);
        end
        if (hit) checkOutput($sformatf("rgb(%0d,%0d)", x, y), 32'(rgb), 32'(expRgb));
        else     checkOutput($sformatf("reach(%0d,%0d)", x, y), 32'd0, 32'd1);
    endtask

    initial begin
        int  n;
        int  low;
        int  cnt;
        bit  lowDone;
        bit  seen;
        logic prev;

        #1 reset = 1'b1;
        repeat (3) @(posedge board_clk);
        #2;
        checkOutput("rstHsync", 32'(hsync), 32'd1);
        checkOutput("rstRgb", 32'(rgb), 32'd0);
        reset = 1'b0;

        // First tick arrives in the D-th cycle after release.
        n = 0;
        do begin @(negedge board_clk); n++; end while (!p_tick && n < 20);
        checkOutput("firstTickCycle", 32'(n), 32'd3);

        // Horizontal sync position, width and line period.
        prev = 1'b1; seen = 1'b0; n = 0;
        while (!seen && n < 4 * HT * D) begin
            @(negedge board_clk); n++;
            seen = prev && !hsync;
            prev = hsync;
        end
        checkOutput("hsyncFallX", 32'(pixel_x), 32'd19);
        low = 1; cnt = 0; lowDone = 1'b0; prev = 1'b0;
        while (cnt < 4 * HT * D) begin
            @(negedge board_clk); cnt++;
            if (!lowDone) begin
                if (!hsync) low++;
                else lowDone = 1'b1;
            end
            if (!hsync && prev) break;
            prev = hsync;
        end
        checkOutput("hsyncLowCycles", 32'(low), 32'd12);
        checkOutput("linePeriod", 32'(cnt), 32'd75);

        // Vertical sync position and width.
        prev = 1'b1; seen = 1'b0; n = 0;
        while (!seen && n < 2 * FR * D) begin
            @(negedge board_clk); n++;
            seen = prev && !vsync;
            prev = vsync;
        end
        checkOutput("vsyncFallY", 32'(pixel_y), 32'd12);
        checkOutput("vsyncFallX", 32'(pixel_x), 32'd0);
        low = 1; n = 0;
        while (n < 2 * FR * D) begin
            @(negedge board_clk); n++;
            if (vsync) break;
            low++;
        end
        checkOutput("vsyncLowCycles", 32'(low), 32'd225);

        // Two overlapping layers written late in frame 0, shown from frame 1.
        applyStimulus(0, 3, 6, 2, 4, 3'b010, 1'b1);
        applyStimulus(1, 5, 9, 3, 7, 3'b110, 1'b1);
        waitFrameStart(2 * FR * D);
        checkPixel(2, 2, 3'b101);
        checkPixel(3, 2, 3'b010);
        checkPixel(5, 3, 3'b010);
        checkPixel(20, 3, 3'b000);
        checkPixel(6, 4, 3'b010);
        checkPixel(7, 4, 3'b110);
        checkPixel(9, 7, 3'b110);
        checkPixel(10, 7, 3'b101);

        // Write landing exactly on the frame-boundary copy cycle.
        seen = 1'b0; n = 0;
        while (!seen && n < 2 * FR * D) begin
            @(negedge board_clk); n++;
            seen = (int'(pixel_x) == HT - 2) && (int'(pixel_y) == VT - 1) && p_tick;
        end
        checkOutput("copyCycleFound", 32'(seen), 32'd1);
        wr_en = 1'b1; wr_idx = 2'd2;
        wr_x1 = 6'd12; wr_x2 = 6'd14; wr_y1 = 6'd8; wr_y2 = 6'd9;
        wr_rgb = 3'b011; wr_vis = 1'b1;
        @(posedge board_clk); #2;
        wr_en = 1'b0;
        checkPixel(13, 8, 3'b101);
        waitFrameStart(2 * FR * D);
        checkPixel(12, 8, 3'b011);
        checkPixel(13, 8, 3'b011);
        checkPixel(14, 9, 3'b011);
        checkPixel(15, 9, 3'b101);

        // Reset in the middle of a frame.
        checkPixel(10, 5, 3'b101);
        @(posedge board_clk); #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstRgb", 32'(rgb), 32'd0);
        checkOutput("midRstVideoOn", 32'(video_on), 32'd0);
        checkOutput("midRstPixelX", 32'(pixel_x), 32'd0);
        repeat (3) @(posedge board_clk);
        #2 reset = 1'b0;
        waitFrameStart(20);
        checkOutput("recoverPixelX", 32'(pixel_x), 32'd0);
        checkOutput("recoverPixelY", 32'(pixel_y), 32'd0);
        checkOutput("recoverRgb", 32'(rgb), 32'(BG));
        checkPixel(3, 2, 3'b101);
        checkPixel(13, 8, 3'b101);

        // Random shadow traffic, including out-of-range indices and inverted bounds.
        for (int k = 0; k < 10 * FR * D; k++) begin
            @(posedge board_clk); #2;
            wr_en  = ($urandom_range(0, 15) == 0);
            wr_idx = 2'($urandom_range(0, 3));
            wr_x1  = 6'($urandom_range(0, 18));
            wr_x2  = 6'($urandom_range(0, 22));
            wr_y1  = 6'($urandom_range(0, 11));
            wr_y2  = 6'($urandom_range(0, 14));
            wr_rgb = 3'($urandom_range(0, 7));
            wr_vis = ($urandom_range(0, 3) != 0);
        end
        @(posedge board_clk); #2;
        wr_en = 1'b0;
        repeat (2 * FR * D) @(posedge board_clk);

        @(negedge board_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
